// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types for the FFT stage controller: complex sample
//               layout, controller state encoding and sign-magnitude halving.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_e;

    // Sign-magnitude: halve the magnitude, keep the sign bit as it was.
    function automatic complex_t sm_half(input complex_t c);
        complex_t r;
        r.re = {c.re[DW-1], 1'b0, c.re[DW-2:1]};
        r.im = {c.im[DW-1], 1'b0, c.im[DW-2:1]};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_gen
// Description : Combinational radix-2 DIT operand/twiddle address generator,
//               (stage, k) -> (addr_a, addr_b, tw_addr).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_gen #(
    parameter int LOG2N = 5
) (
    input  logic [$clog2(LOG2N)-1:0] stage_i,
    input  logic [LOG2N-2:0]         k_i,
    output logic [LOG2N-1:0]         addr_a_o,
    output logic [LOG2N-1:0]         addr_b_o,
    output logic [LOG2N-2:0]         tw_addr_o
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;

    logic [KW-1:0] w_j;
    logic [KW-1:0] w_g;
    logic [SW:0]   w_stage_p1;
    logic [SW:0]   w_tw_shift;

    // j = position inside a group, g = group number
    assign w_j        = k_i & ~({KW{1'b1}} << stage_i);
    assign w_g        = k_i >> stage_i;
    assign w_stage_p1 = {1'b0, stage_i} + (SW+1)'(1);
    assign w_tw_shift = (SW+1)'(KW) - {1'b0, stage_i};

    assign addr_a_o  = ({1'b0, w_g} << w_stage_p1) | {1'b0, w_j};
    assign addr_b_o  = addr_a_o | (LOG2N'(1) << stage_i);
    assign tw_addr_o = w_j << w_tw_shift;

endmodule
`default_nettype wire

// File: rtl/fft_stage_controller.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_controller
// Description : Sequences an in-place radix-2 DIT FFT over a dual-port RAM,
//               two cycles per butterfly. Define FFT_SCALE_EN to halve every
//               written component (1/N overall scaling).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_controller
    import fft_pkg::*;
#(
    parameter int LOG2N = 5,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [LOG2N-1:0]         ram_addr_a,
    output logic [LOG2N-1:0]         ram_addr_b,
    output logic                     ram_we,
    input  logic [2*DW-1:0]          ram_rdata_a,
    input  logic [2*DW-1:0]          ram_rdata_b,
    output logic [2*DW-1:0]          ram_wdata_a,
    output logic [2*DW-1:0]          ram_wdata_b,
    output logic [LOG2N-2:0]         tw_addr,
    input  logic [2*DW-1:0]          tw_data,
    output logic [2*DW-1:0]          bf_in1,
    output logic [2*DW-1:0]          bf_in2,
    output logic [2*DW-1:0]          bf_tw,
    input  logic [2*DW-1:0]          bf_out1,
    input  logic [2*DW-1:0]          bf_out2,
    output logic [$clog2(LOG2N)-1:0] stage
);

    localparam int SW = $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0] c_k_last     = '1;
    localparam logic [SW-1:0] c_stage_last = SW'(LOG2N - 1);

    ctrl_state_e      state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LOG2N-1:0] w_addr_a, w_addr_b;
    logic [KW-1:0]    w_tw_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            ST_RD: state_d = ST_WR;
            ST_WR: begin
                if (k_q == c_k_last) begin
                    k_d = '0;
                    if (stage_q == c_stage_last) begin
                        stage_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = ST_RD;
                    end
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ST_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage_i   (stage_q),
        .k_i       (k_q),
        .addr_a_o  (w_addr_a),
        .addr_b_o  (w_addr_b),
        .tw_addr_o (w_tw_addr)
    );

    assign busy   = (state_q == ST_RD) || (state_q == ST_WR);
    assign done   = (state_q == ST_DONE);
    assign ram_we = (state_q == ST_WR);
    assign stage  = stage_q;

    // Addresses idle at zero outside a run so the RAM sees a quiet bus.
    assign ram_addr_a = busy ? w_addr_a  : '0;
    assign ram_addr_b = busy ? w_addr_b  : '0;
    assign tw_addr    = busy ? w_tw_addr : '0;

    assign bf_in1 = ram_rdata_a;
    assign bf_in2 = ram_rdata_b;
    assign bf_tw  = tw_data;

`ifdef FFT_SCALE_EN
    // complex_t follows fft_pkg::DW; keep the DW parameter equal to it.
    assign ram_wdata_a = sm_half(complex_t'(bf_out1));
    assign ram_wdata_b = sm_half(complex_t'(bf_out2));
`else
    assign ram_wdata_a = bf_out1;
    assign ram_wdata_b = bf_out2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_controller
// Description : Self-checking bench: N=8 instance for sequencing/data/reset,
//               N=32 instance for the full impulse transform.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_stage_controller;

`ifdef FFT_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- arithmetic helpers (sign-magnitude Q8.8) ----------------
    function automatic int sm2i(input logic [15:0] v);
        return v[15] ? -int'({1'b0, v[14:0]}) : int'({1'b0, v[14:0]});
    endfunction

    function automatic logic [15:0] i2sm(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (m > 32767) m = 32767;
        return {(v < 0), m[14:0]};
    endfunction

    function automatic logic [31:0] cplx(input int re, input int im);
        return {i2sm(re), i2sm(im)};
    endfunction

    function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] w, input bit sub);
        int ar, ai, br, bi, wr, wi, pr, pi;
        ar = sm2i(a[31:16]); ai = sm2i(a[15:0]);
        br = sm2i(b[31:16]); bi = sm2i(b[15:0]);
        wr = sm2i(w[31:16]); wi = sm2i(w[15:0]);
        pr = (br * wr - bi * wi) / 256;
        pi = (br * wi + bi * wr) / 256;
        return sub ? cplx(ar - pr, ai - pi) : cplx(ar + pr, ai + pi);
    endfunction

    function automatic logic [31:0] sc(input logic [31:0] c);
        if (SCALE) return {c[31], 1'b0, c[30:17], c[15], 1'b0, c[14:1]};
        return c;
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [31:0] tw_val(input int i, input int n);
        real ang;
        ang = 6.283185307179586 * i / n;
        return cplx(rnd(256.0 * $cos(ang)), rnd(-256.0 * $sin(ang)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- N=8 instance ----------------
    logic        start3, busy3, done3, we3, ld3;
    logic [2:0]  aa3, ab3, ld3_addr;
    logic [1:0]  tw3, stage3;
    logic [31:0] rda3, rdb3, wda3, wdb3, twd3, bi1_3, bi2_3, btw3, bo1_3, bo2_3, ld3_data;
    logic [31:0] ram3 [8];
    logic [31:0] rom3 [4];
    logic [31:0] ref3 [8];

    fft_stage_controller #(.LOG2N(3), .DW(16)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .ram_addr_a(aa3), .ram_addr_b(ab3), .ram_we(we3),
        .ram_rdata_a(rda3), .ram_rdata_b(rdb3), .ram_wdata_a(wda3), .ram_wdata_b(wdb3),
        .tw_addr(tw3), .tw_data(twd3), .bf_in1(bi1_3), .bf_in2(bi2_3), .bf_tw(btw3),
        .bf_out1(bo1_3), .bf_out2(bo2_3), .stage(stage3)
    );

    assign bo1_3 = bfly(bi1_3, bi2_3, btw3, 1'b0);
    assign bo2_3 = bfly(bi1_3, bi2_3, btw3, 1'b1);

    always @(posedge clk) begin
        rda3 <= ram3[aa3];
        rdb3 <= ram3[ab3];
        twd3 <= rom3[tw3];
        if (ld3) ram3[ld3_addr] <= ld3_data;
        else if (we3) begin
            ram3[aa3] <= wda3;
            ram3[ab3] <= wdb3;
        end
    end

    // ---------------- N=32 instance ----------------
    logic        start5, busy5, done5, we5, ld5;
    logic [4:0]  aa5, ab5, ld5_addr;
    logic [3:0]  tw5;
    logic [2:0]  stage5;
    logic [31:0] rda5, rdb5, wda5, wdb5, twd5, bi1_5, bi2_5, btw5, bo1_5, bo2_5, ld5_data;
    logic [31:0] ram5 [32];
    logic [31:0] rom5 [16];

    fft_stage_controller #(.LOG2N(5), .DW(16)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
        .ram_addr_a(aa5), .ram_addr_b(ab5), .ram_we(we5),
        .ram_rdata_a(rda5), .ram_rdata_b(rdb5), .ram_wdata_a(wda5), .ram_wdata_b(wdb5),
        .tw_addr(tw5), .tw_data(twd5), .bf_in1(bi1_5), .bf_in2(bi2_5), .bf_tw(btw5),
        .bf_out1(bo1_5), .bf_out2(bo2_5), .stage(stage5)
    );

    assign bo1_5 = bfly(bi1_5, bi2_5, btw5, 1'b0);
    assign bo2_5 = bfly(bi1_5, bi2_5, btw5, 1'b1);

    always @(posedge clk) begin
        rda5 <= ram5[aa5];
        rdb5 <= ram5[ab5];
        twd5 <= rom5[tw5];
        if (ld5) ram5[ld5_addr] <= ld5_data;
        else if (we5) begin
            ram5[aa5] <= wda5;
            ram5[ab5] <= wdb5;
        end
    end

    // ---------------- vector tables ----------------
    typedef struct {
        logic [1:0] st;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } addr_vec_t;

    typedef struct {
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } data_vec_t;

    addr_vec_t avec [12];
    data_vec_t dvec [3];

    // ---------------- tasks ----------------
    task automatic reset_all();
        rst = 1'b1; start3 = 1'b0; start5 = 1'b0; ld3 = 1'b0; ld5 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load3(input int addr, input logic [31:0] d);
        ld3 = 1'b1; ld3_addr = addr[2:0]; ld3_data = d;
        @(negedge clk);
        ld3 = 1'b0;
    endtask

    task automatic load5(input int addr, input logic [31:0] d);
        ld5 = 1'b1; ld5_addr = addr[4:0]; ld5_data = d;
        @(negedge clk);
        ld5 = 1'b0;
    endtask

    // Whole-transform reference: loop over stages, groups and butterflies.
    task automatic ref_fft3();
        for (int s = 0; s < 3; s++) begin
            int span;
            span = 1 << s;
            for (int base = 0; base < 8; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    logic [31:0] w, x, y;
                    w = rom3[j * (8 / (2 * span))];
                    x = ref3[base + j];
                    y = ref3[base + j + span];
                    ref3[base + j]        = sc(bfly(x, y, w, 1'b0));
                    ref3[base + j + span] = sc(bfly(x, y, w, 1'b1));
                end
            end
        end
    endtask

    task automatic run3(input bit poke, output int cyc);
        int idx, busy_bad;
        idx = 0; busy_bad = 0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 1;
        while (!done3 && cyc < 200) begin
            if (!busy3) busy_bad++;
            if (we3) begin
                if (idx < 12)
                    check($sformatf("addr_%0d", idx), 32'({stage3, aa3, ab3, tw3}),
                          32'({avec[idx].st, avec[idx].a, avec[idx].b, avec[idx].tw}));
                idx++;
            end
            start3 = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("latency3", cyc, 25);
        check("wr_count3", idx, 12);
        check("busy_during3", busy_bad, 0);
        start3 = poke;
        @(negedge clk);
        check("after_done3", 32'({busy3, done3, we3}), 0);
        start3 = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int cyc, bad, n;
        logic [31:0] e;

        avec[0]  = '{2'd0, 3'd0, 3'd1, 2'd0}; avec[1]  = '{2'd0, 3'd2, 3'd3, 2'd0};
        avec[2]  = '{2'd0, 3'd4, 3'd5, 2'd0}; avec[3]  = '{2'd0, 3'd6, 3'd7, 2'd0};
        avec[4]  = '{2'd1, 3'd0, 3'd2, 2'd0}; avec[5]  = '{2'd1, 3'd1, 3'd3, 2'd2};
        avec[6]  = '{2'd1, 3'd4, 3'd6, 2'd0}; avec[7]  = '{2'd1, 3'd5, 3'd7, 2'd2};
        avec[8]  = '{2'd2, 3'd0, 3'd4, 2'd0}; avec[9]  = '{2'd2, 3'd1, 3'd5, 2'd1};
        avec[10] = '{2'd2, 3'd2, 3'd6, 2'd2}; avec[11] = '{2'd2, 3'd3, 3'd7, 2'd3};

        dvec[0] = '{cplx(1280, 1024), cplx(768, 512),   cplx(2048, 1536), cplx(512, 512)};
        dvec[1] = '{cplx(256, 0),     cplx(0, 256),     cplx(256, 256),   cplx(256, -256)};
        dvec[2] = '{cplx(-512, 256),  cplx(256, -768),  cplx(-256, -512), cplx(-768, 1024)};

        for (int i = 0; i < 4; i++)  rom3[i] = tw_val(i, 8);
        for (int i = 0; i < 16; i++) rom5[i] = tw_val(i, 32);

        ld3_addr = '0; ld3_data = '0; ld5_addr = '0; ld5_data = '0;
        reset_all();

        // Idle after reset: every control output quiet, both instances.
        for (int c = 0; c < 6; c++) begin
            check("idle3", 32'({busy3, done3, we3, aa3, ab3, tw3, stage3}), 0);
            check("idle5", 32'({busy5, done5, we5, aa5, ab5, tw5, stage5}), 0);
            @(negedge clk);
        end

        // Random full transforms; later runs also toggle start while busy.
        for (int r = 0; r < 3; r++) begin
            reset_all();
            for (int i = 0; i < 8; i++) begin
                logic [31:0] v;
                v = cplx(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
                load3(i, v);
                ref3[i] = v;
            end
            run3(r > 0, cyc);
            ref_fft3();
            for (int i = 0; i < 8; i++)
                check($sformatf("bin3_r%0d_%0d", r, i), ram3[i], ref3[i]);
        end

        // First write-back data of a run.
        for (int i = 0; i < 3; i++) begin
            reset_all();
            load3(0, dvec[i].in0);
            load3(1, dvec[i].in1);
            start3 = 1'b1;
            @(negedge clk);
            start3 = 1'b0;
            n = 0;
            while (!we3 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("dp%0d_we", i), 32'(we3), 1);
            check($sformatf("dp%0d_wa", i), wda3, sc(dvec[i].exp0));
            check($sformatf("dp%0d_wb", i), wdb3, sc(dvec[i].exp1));
        end

        // Reset in the middle of a run.
        reset_all();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_at_c10", 32'(busy3), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst", 32'({busy3, done3, we3, aa3, ab3, tw3, stage3}), 0);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy3 || done3 || we3) bad++;
        end
        check("no_activity_after_rst", bad, 0);

        // N=32 impulse transform.
        reset_all();
        for (int i = 0; i < 32; i++) load5(i, (i == 0) ? cplx(256, 0) : 32'h0);
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        cyc = 1;
        while (!done5 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("latency5", cyc, 161);
        e = cplx(256, 0);
        repeat (5) e = sc(e);
        for (int i = 0; i < 32; i++)
            check($sformatf("bin5_%0d", i), ram5[i], e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
